ifu_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction decoder/legality check. Owns the PC, issues
//  one 32-bit fetch at a time to instruction memory over a valid/ready handshake, and holds the fetched

---
 rtl/npc_pkg.sv | 22 ++
 rtl/ifu_fetch.sv | 124 ++++++++++++
 tb/tb_ifu_fetch.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared fetch-side types and constants.
// Imported by the fetch stage and its bench.
package npc_pkg;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          INST_W   = 32;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, one outstanding imem request,
// holds the fetched word until decode takes it; redirects squash.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int                XLEN_P     = XLEN,
  parameter logic [XLEN_P-1:0] RESET_PC_P = XLEN_P'(RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN_P-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN_P-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN_P-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic              out_fetch_err
);

  fetch_state_e      state, state_n;
  logic [XLEN_P-1:0] pc, pc_n;
  logic              drop, drop_n;
  logic [INST_W-1:0] inst, inst_n;
  logic              err, err_n;
  logic              aligned;
  logic              hs;

  assign aligned = (pc[1:0] == 2'b00);
  assign hs      = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc    <= RESET_PC_P;
      drop  <= 1'b0;
      inst  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
      inst  <= inst_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    drop_n         = drop;
    inst_n         = inst;
    err_n          = err;
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    case (state)
      REQ: begin
        imem_req_valid = aligned;
        if (redirect_valid) begin
          pc_n = redirect_pc;
          // request already accepted: its response must be dropped
          if (hs) begin
            state_n = WAIT;
            drop_n  = 1'b1;
          end
        end else if (!aligned) begin
          state_n = HOLD;
          inst_n  = '0;
          err_n   = 1'b1;
        end else if (hs) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (imem_rsp_valid) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else begin
            drop_n = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else begin
            state_n = HOLD;
            inst_n  = imem_rsp_err ? '0 : imem_rsp_data;
            err_n   = imem_rsp_err;
          end
        end
      end
      HOLD: begin
        out_valid = ~redirect_valid;
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = REQ;
        end else if (out_ready) begin
          pc_n    = pc + XLEN_P'(4);
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

  assign imem_req_addr = pc;
  assign out_pc        = pc;
  assign out_inst      = inst;
  assign out_fetch_err = err;
  assign out_opcode    = inst[OPC_MSB:OPC_LSB];
  assign out_funct3    = inst[F3_MSB:F3_LSB];
  assign out_funct7    = inst[F7_MSB:F7_LSB];

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed stimulus, imem model,
// and a scoreboard monitor on accepted decode packets.
module tb_ifu_fetch;
  import npc_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } pkt_t;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_fetch_err;

  int   total = 0;
  int   passed = 0;
  pkt_t sb[$];

  int          lat = 1;
  logic [63:0] err_addr = '1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [63:0] paddr = '0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_opcode     (out_opcode),
    .out_funct3     (out_funct3),
    .out_funct7     (out_funct7),
    .out_fetch_err  (out_fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return {a[11:0], 20'h00413};
  endfunction

  // imem: lat=1 answers in the cycle after the accept edge
  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    imem_rsp_err   <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_err   <= (paddr == err_addr);
          imem_rsp_data  <= (paddr == err_addr) ?
                            32'hDEAD_BEEF : word(paddr);
          pend <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        if (lat <= 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_err   <= (imem_req_addr == err_addr);
          imem_rsp_data  <= (imem_req_addr == err_addr) ?
                            32'hDEAD_BEEF : word(imem_req_addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= lat - 1;
          paddr <= imem_req_addr;
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pkt_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        pkt_t e;
        logic [31:0] ei;
        e  = sb.pop_front();
        ei = e.inst;
        chk("sb_pc", out_pc, e.pc);
        chk("sb_inst", 64'(out_inst), 64'(ei));
        chk("sb_err", 64'(out_fetch_err), 64'(e.err));
        chk("sb_opcode", 64'(out_opcode), 64'(ei[6:0]));
        chk("sb_funct3", 64'(out_funct3), 64'(ei[14:12]));
        chk("sb_funct7", 64'(out_funct7), 64'(ei[31:25]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) chk({name, "_out_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_req(input string name,
                          input logic [63:0] addr);
    int n = 0;
    while (!imem_req_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_req_valid"}, 64'(imem_req_valid), 64'd1);
    chk({name, "_req_addr"}, imem_req_addr, addr);
  endtask

  task automatic take(input string name,
                      input logic [63:0] pc,
                      input logic [31:0] inst,
                      input logic err);
    pkt_t p;
    wait_out(name);
    p.pc   = pc;
    p.inst = inst;
    p.err  = err;
    sb.push_back(p);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hpc;
    logic [31:0] hinst;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd1);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    rst = 1'b0;

    // basic fetch and field split
    wait_out("t1");
    chk("t1_pc", out_pc, RST_PC);
    chk("t1_inst", 64'(out_inst), 64'h0000_0413);
    chk("t1_opcode", 64'(out_opcode), 64'h13);
    chk("t1_funct3", 64'(out_funct3), 64'h0);
    chk("t1_funct7", 64'(out_funct7), 64'h0);
    chk("t1_err", 64'(out_fetch_err), 64'd0);

    // decode stall in HOLD
    hpc   = out_pc;
    hinst = out_inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
      chk("t2_pc", out_pc, hpc);
      chk("t2_inst", 64'(out_inst), 64'(hinst));
    end
    take("t1", RST_PC, 32'h0000_0413, 1'b0);
    chk("t1_next_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t1_next_req_addr", imem_req_addr, 64'h8000_0004);

    // redirect while WAIT; late response dropped
    lat = 3;
    tick();
    redirect(64'h8000_0100);
    lat = 1;
    wait_req("t3", 64'h8000_0100);
    take("t3", 64'h8000_0100, 32'h1000_0413, 1'b0);

    // redirect coinciding with the response
    tick();
    redirect(64'h8000_0200);
    chk("t4a_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t4a_req_addr", imem_req_addr, 64'h8000_0200);
    take("t4a", 64'h8000_0200, 32'h2000_0413, 1'b0);

    // redirect coinciding with decode accept
    wait_out("t4b");
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    #1;
    chk("t4b_out_forced0", 64'(out_valid), 64'd0);
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    wait_req("t4b", 64'h8000_0300);
    take("t4b", 64'h8000_0300, 32'h3000_0413, 1'b0);

    // misaligned target and access fault
    imem_req_ready = 1'b0;
    redirect(64'h8000_0102);
    imem_req_ready = 1'b1;
    chk("t5_misal_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t5_misal_addr", imem_req_addr, 64'h8000_0102);
    take("t5_misal", 64'h8000_0102, 32'h0, 1'b1);
    err_addr = 64'h8000_0008;
    redirect(64'h8000_0008);
    take("t5_fault", 64'h8000_0008, 32'h0, 1'b1);

    // redirect on the request handshake cycle
    redirect(64'h8000_0400);
    wait_req("t5b", 64'h8000_0400);
    take("t5b", 64'h8000_0400, 32'h4000_0413, 1'b0);

    // reset in WAIT (with drop pending), then in HOLD
    lat = 3;
    tick();
    redirect(64'h8000_0500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat = 1;
    chk("t6w_out_valid", 64'(out_valid), 64'd0);
    chk("t6w_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t6w_req_addr", imem_req_addr, RST_PC);
    wait_out("t6h");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6h_out_valid", 64'(out_valid), 64'd0);
    chk("t6h_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t6h_req_addr", imem_req_addr, RST_PC);
    take("t6", RST_PC, 32'h0000_0413, 1'b0);

    repeat (4) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
